fsm_vending_param: RTL and testbench
====================================

Name: fsm_vending_param

Overview:
Parametrised successor of the team's two-coin vending FSM. It accepts three coin denominations, keeps a registered credit accumulator and vends against a parameterised price. It returns change as a counted train of coin pulses, and supports cancel/refund and handshaked product dispense. It sits between the coin-acceptor debouncers and the dispenser/coin-hopper drivers.

Parameters:
CREDIT_W, 8, width of credit accumulator (bits)
PRICE, 15, product price in credit units
VAL_A, 5, value of coin input in_cinco
VAL_B, 10, value of coin input in_diez
VAL_C, 25, value of coin input in_veinticinco
MAX_CREDIT, 95, maximum credit accepted; must be < 2**CREDIT_W
CHANGE_UNIT, 5, value of one change coin; PRICE, VAL_A/B/C and MAX_CREDIT must all be multiples of it
TIMEOUT_CYC, 1000, idle cycles before auto-refund (optional feature only)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in_cinco  input  1  coin A pulse, one cycle per coin
in_diez  input  1  coin B pulse
in_veinticinco  input  1  coin C pulse
cancel  input  1  refund request pulse
dispense_ack  input  1  dispenser has delivered product
producto  output  1  dispense request, level, registered
cambio  output  1  one change coin per high cycle, registered
coin_reject  output  1  one-cycle pulse, coin returned uncredited
credit  output  CREDIT_W  current credit, registered
busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; credit=0; producto=0, cambio=0, coin_reject=0, busy=0.
- States: IDLE (credit==0), CREDIT (0<credit<PRICE), VEND, CHANGE. All outputs are registered and have no combinational paths from inputs.
- Coin sampling happens in IDLE/CREDIT only, one decision per rising edge:
  - Exactly one coin input high and credit+val <= MAX_CREDIT: credit <= credit+val on that edge.
  - Exactly one coin input high and sum > MAX_CREDIT: coin_reject=1 for the following cycle; credit unchanged.
  - Two or more coin inputs high in the same cycle: coin_reject pulse; credit unchanged.
- The sum is computed at CREDIT_W+1 bits, so overflow never wraps.
- Transition to VEND: evaluated on the registered credit. If credit >= PRICE at edge N, state=VEND and producto=1 after edge N+1. Coin-to-producto latency is 2 edges.
- VEND:
  - producto is held high until dispense_ack is sampled high.
  - On that edge: producto <= 0; credit <= credit-PRICE; next state is CHANGE if the remainder is >0, else IDLE.
  - dispense_ack outside VEND is ignored.
- CHANGE:
  - Alternates cambio high one cycle, low one cycle.
  - Each high cycle decrements credit by CHANGE_UNIT on its closing edge.
  - The state exits to IDLE on the edge where credit reaches 0, with cambio=0.
  - The number of cambio pulses is exactly remainder/CHANGE_UNIT.
- cancel:
  - In CREDIT: next state is CHANGE, which refunds the full credit. No producto.
  - In IDLE: no effect.
  - In VEND/CHANGE: ignored.
  - If cancel and a coin arrive in the same cycle in CREDIT, cancel wins and the coin is rejected (coin_reject pulse).
- Any coin sampled in VEND/CHANGE: coin_reject pulse; credit unchanged.
- Reset mid-operation clears everything immediately. Held credit is lost and no change is paid; this is documented system behaviour.
- Illegal or unused state encodings recover to IDLE on the next edge with credit cleared.
- busy=1 exactly while state is VEND or CHANGE.

Optional Feature:
- Macro: FSM_VENDING_TIMEOUT_EN.
- When defined:
  - An idle counter ($clog2(TIMEOUT_CYC+1) bits) runs in CREDIT.
  - It resets on every accepted or rejected coin, and is cleared in all other states.
  - On reaching TIMEOUT_CYC it forces CHANGE (auto-refund), behaving exactly as cancel.
- When undefined: no counter is present and CREDIT waits indefinitely.

Test Plan:
- Reset low mid-CHANGE with credit=10 -> all outputs 0 asynchronously; credit=0 and state IDLE after release.
- in_cinco, then in_diez (defaults) -> credit 5, then 15; producto high 2 edges after the in_diez edge; hold until dispense_ack -> credit 0, IDLE, zero cambio pulses.
- in_veinticinco alone -> producto; on ack credit=10; exactly 2 cambio pulses separated by a low cycle; then IDLE with busy=0.
- in_cinco + in_diez in the same cycle -> coin_reject 1-cycle pulse; credit stays 0. Credit 90 + in_diez -> reject; credit stays 90.
- Credit 10 via in_diez, then cancel together with in_cinco -> coin_reject; 2 cambio pulses; producto never asserted.
- With FSM_VENDING_TIMEOUT_EN and TIMEOUT_CYC=20: in_cinco, then idle 20 cycles -> CHANGE entered; 1 cambio pulse. Without the macro, the same stimulus leaves credit 5 indefinitely.

Source files
------------

// File: rtl/fsm_vending_param.sv
// fsm_vending_param: three-coin vending FSM with credit accumulator, change train, cancel and optional FSM_VENDING_TIMEOUT_EN auto-refund
module fsm_vending_param #(
    parameter int CREDIT_W    = 8,
    parameter int PRICE       = 15,
    parameter int VAL_A       = 5,
    parameter int VAL_B       = 10,
    parameter int VAL_C       = 25,
    parameter int MAX_CREDIT  = 95,
    parameter int CHANGE_UNIT = 5,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_cinco,
    input  logic                in_diez,
    input  logic                in_veinticinco,
    input  logic                cancel,
    input  logic                dispense_ack,
    output logic                producto,
    output logic                cambio,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CREDIT = 3'd1,
        S_VEND   = 3'd2,
        S_CHANGE = 3'd3
    } state_t;

    localparam logic [CREDIT_W:0]   VA      = (CREDIT_W+1)'(VAL_A);
    localparam logic [CREDIT_W:0]   VB      = (CREDIT_W+1)'(VAL_B);
    localparam logic [CREDIT_W:0]   VC      = (CREDIT_W+1)'(VAL_C);
    localparam logic [CREDIT_W:0]   MAXC    = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                producto_q, producto_d;
    logic                cambio_q, cambio_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;
    logic [1:0]          coin_n;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                coin_ok;
    logic                refund;
    logic                timeout;

    // The sum carries one extra bit so an over-cap coin can never wrap into range
    assign coin_n   = {1'b0, in_cinco} + {1'b0, in_diez} + {1'b0, in_veinticinco};
    assign coin_val = in_cinco ? VA : in_diez ? VB : VC;
    assign sum      = {1'b0, credit_q} + coin_val;
    assign coin_ok  = (coin_n == 2'd1) && (sum <= MAXC);

`ifdef FSM_VENDING_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    assign timeout = (tmo_q == TW'(TIMEOUT_CYC));

    // Idle counter: runs only while waiting in CREDIT, any coin restarts it
    always_comb begin
        tmo_d = (state_q != S_CREDIT || coin_n != 2'd0 || timeout) ? '0 : tmo_q + TW'(1);
    end

    // Idle counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_q <= '0;
        else      tmo_q <= tmo_d;
    end
`else
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    // Next-state, credit and registered-output decode
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        producto_d    = 1'b0;
        cambio_d      = 1'b0;
        coin_reject_d = (coin_n != 2'd0);
        refund        = 1'b0;
        case (state_q)
            S_IDLE, S_CREDIT: begin
                refund = (cancel && state_q == S_CREDIT) || timeout;
                if (credit_q >= PRICE_C) begin
                    state_d    = S_VEND;
                    producto_d = 1'b1;
                end else if (refund) begin
                    state_d = S_CHANGE;
                end else if (coin_ok) begin
                    credit_d      = sum[CREDIT_W-1:0];
                    coin_reject_d = 1'b0;
                    state_d       = S_CREDIT;
                end else begin
                    state_d = (credit_q == '0) ? S_IDLE : S_CREDIT;
                end
            end
            S_VEND: begin
                producto_d = !dispense_ack;
                if (dispense_ack) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = (credit_q == PRICE_C) ? S_IDLE : S_CHANGE;
                end
            end
            S_CHANGE: begin
                cambio_d = !cambio_q && (credit_q != '0);
                credit_d = cambio_q ? credit_q - UNIT_C : credit_q;
                state_d  = (credit_q == '0 || (cambio_q && credit_q == UNIT_C)) ? S_IDLE : S_CHANGE;
            end
            default: begin
                state_d       = S_IDLE;
                credit_d      = '0;
                coin_reject_d = 1'b0;
            end
        endcase
        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            producto_q    <= 1'b0;
            cambio_q      <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            producto_q    <= producto_d;
            cambio_q      <= cambio_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign producto    = producto_q;
    assign cambio      = cambio_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_fsm_vending_param.sv
// tb_fsm_vending_param: vector table plus scoreboard queue against two vending FSM instances
module tb_fsm_vending_param;
    typedef struct {
        logic       p;
        logic       c;
        logic       r;
        logic [7:0] cr;
        logic       b;
    } exp_t;

    typedef struct {
        logic [4:0] in;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cinco = 0, diez = 0, veint = 0, cancel = 0, ack = 0;
    logic d2_cinco = 0, d2_diez = 0, d2_veint = 0, d2_cancel = 0, d2_ack = 0;
    logic p1, c1, r1, b1, p2, c2, r2, b2;
    logic [7:0] cr1, cr2;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    vec_t tbl[23];

    always #5 clk = ~clk;

    fsm_vending_param #(.TIMEOUT_CYC(20)) dut1 (
        .clk(clk), .rst(rst), .in_cinco(cinco), .in_diez(diez), .in_veinticinco(veint),
        .cancel(cancel), .dispense_ack(ack), .producto(p1), .cambio(c1),
        .coin_reject(r1), .credit(cr1), .busy(b1)
    );

    fsm_vending_param #(.PRICE(95)) dut2 (
        .clk(clk), .rst(rst), .in_cinco(d2_cinco), .in_diez(d2_diez), .in_veinticinco(d2_veint),
        .cancel(d2_cancel), .dispense_ack(d2_ack), .producto(p2), .cambio(c2),
        .coin_reject(r2), .credit(cr2), .busy(b2)
    );

    function automatic vec_t mk(input logic [4:0] in, input logic p, input logic c,
                                input logic r, input logic [7:0] cr, input logic b);
        vec_t v;
        v.in = in;
        v.e.p = p;
        v.e.c = c;
        v.e.r = r;
        v.e.cr = cr;
        v.e.b = b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic cmp(input string nm, input exp_t a);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty got=0 exp=1", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, ".producto"}, 8'(a.p), 8'(e.p));
            chk({nm, ".cambio"}, 8'(a.c), 8'(e.c));
            chk({nm, ".coin_reject"}, 8'(a.r), 8'(e.r));
            chk({nm, ".credit"}, a.cr, e.cr);
            chk({nm, ".busy"}, 8'(a.b), 8'(e.b));
        end
    endtask

    task automatic step(input bit d2, input vec_t v, input string nm);
        exp_t a;
        if (d2) {d2_cinco, d2_diez, d2_veint, d2_cancel, d2_ack} = v.in;
        else    {cinco, diez, veint, cancel, ack} = v.in;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        {cinco, diez, veint, cancel, ack} = 5'b0;
        {d2_cinco, d2_diez, d2_veint, d2_cancel, d2_ack} = 5'b0;
        if (d2) begin
            a.p = p2; a.c = c2; a.r = r2; a.cr = cr2; a.b = b2;
        end else begin
            a.p = p1; a.c = c1; a.r = r1; a.cr = cr1; a.b = b1;
        end
        cmp(nm, a);
    endtask

    initial begin
        int n;
        int k;
        // inputs: {in_cinco, in_diez, in_veinticinco, cancel, dispense_ack}
        tbl[0]  = mk(5'b10000, 0, 0, 0, 5,  0);
        tbl[1]  = mk(5'b01000, 0, 0, 0, 15, 0);
        tbl[2]  = mk(5'b00000, 1, 0, 0, 15, 1);
        tbl[3]  = mk(5'b10000, 1, 0, 1, 15, 1);
        tbl[4]  = mk(5'b00001, 0, 0, 0, 0,  0);
        tbl[5]  = mk(5'b00000, 0, 0, 0, 0,  0);
        tbl[6]  = mk(5'b00100, 0, 0, 0, 25, 0);
        tbl[7]  = mk(5'b00000, 1, 0, 0, 25, 1);
        tbl[8]  = mk(5'b00001, 0, 0, 0, 10, 1);
        tbl[9]  = mk(5'b00000, 0, 1, 0, 10, 1);
        tbl[10] = mk(5'b00000, 0, 0, 0, 5,  1);
        tbl[11] = mk(5'b00000, 0, 1, 0, 5,  1);
        tbl[12] = mk(5'b00000, 0, 0, 0, 0,  0);
        tbl[13] = mk(5'b00001, 0, 0, 0, 0,  0);
        tbl[14] = mk(5'b11000, 0, 0, 1, 0,  0);
        tbl[15] = mk(5'b00000, 0, 0, 0, 0,  0);
        tbl[16] = mk(5'b01000, 0, 0, 0, 10, 0);
        tbl[17] = mk(5'b10010, 0, 0, 1, 10, 1);
        tbl[18] = mk(5'b00000, 0, 1, 0, 10, 1);
        tbl[19] = mk(5'b01000, 0, 0, 1, 5,  1);
        tbl[20] = mk(5'b00000, 0, 1, 0, 5,  1);
        tbl[21] = mk(5'b00000, 0, 0, 0, 0,  0);
        tbl[22] = mk(5'b00010, 0, 0, 0, 0,  0);

        #12;
        chk("rst.producto", 8'(p1), 0);
        chk("rst.cambio", 8'(c1), 0);
        chk("rst.coin_reject", 8'(r1), 0);
        chk("rst.credit", cr1, 0);
        chk("rst.busy", 8'(b1), 0);
        #10 rst = 1'b1;

        for (int i = 0; i < 23; i++) step(0, tbl[i], $sformatf("vec%0d", i));

`ifdef FSM_VENDING_TIMEOUT_EN
        step(0, mk(5'b10000, 0, 0, 0, 5, 0), "tmo_coin");
        n = 0;
        while (!b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tmo_busy", 8'(b1), 1);
        chk("tmo_latency_in_range", 8'(n >= 20 && n <= 22), 1);
        n = 0;
        k = 0;
        while (b1 && n < 20) begin
            if (c1) k++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("tmo_pulses", 8'(k), 1);
        chk("tmo_credit", cr1, 0);
        chk("tmo_idle", 8'(b1), 0);
`else
        step(0, mk(5'b10000, 0, 0, 0, 5, 0), "hold_coin");
        for (int i = 0; i < 30; i++) step(0, mk(5'b00000, 0, 0, 0, 5, 0), $sformatf("hold%0d", i));
        step(0, mk(5'b00010, 0, 0, 0, 5, 1), "hold_cancel");
        step(0, mk(5'b00000, 0, 1, 0, 5, 1), "hold_chg");
        step(0, mk(5'b00000, 0, 0, 0, 0, 0), "hold_done");
`endif

        step(0, mk(5'b00100, 0, 0, 0, 25, 0), "mid_coin");
        step(0, mk(5'b00000, 1, 0, 0, 25, 1), "mid_vend");
        step(0, mk(5'b00001, 0, 0, 0, 10, 1), "mid_ack");
        step(0, mk(5'b00000, 0, 1, 0, 10, 1), "mid_chg");
        #2 rst = 1'b0;
        #1;
        chk("arst.producto", 8'(p1), 0);
        chk("arst.cambio", 8'(c1), 0);
        chk("arst.coin_reject", 8'(r1), 0);
        chk("arst.credit", cr1, 0);
        chk("arst.busy", 8'(b1), 0);
        #4 rst = 1'b1;
        step(0, mk(5'b00000, 0, 0, 0, 0, 0), "arst_after");
        step(0, mk(5'b00000, 0, 0, 0, 0, 0), "arst_idle");

        step(1, mk(5'b00100, 0, 0, 0, 25, 0), "cap_c25a");
        step(1, mk(5'b00100, 0, 0, 0, 50, 0), "cap_c25b");
        step(1, mk(5'b00100, 0, 0, 0, 75, 0), "cap_c25c");
        step(1, mk(5'b01000, 0, 0, 0, 85, 0), "cap_c10");
        step(1, mk(5'b10000, 0, 0, 0, 90, 0), "cap_c5");
        step(1, mk(5'b01000, 0, 0, 1, 90, 0), "cap_over");
        step(1, mk(5'b10000, 0, 0, 0, 95, 0), "cap_exact");
        step(1, mk(5'b00000, 1, 0, 0, 95, 1), "cap_vend");
        step(1, mk(5'b00001, 0, 0, 0, 0,  0), "cap_ack");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
